// File: rtl/wc_tile_feeder_if.sv
// Handshake bundle for wc_tile_feeder: serial sample stream in, 6-sample tile out.
// The master modport belongs to the side that sources samples and consumes tiles.
interface wc_tile_feeder_if #(
  parameter int unsigned DW  = 10,
  parameter int unsigned TAP = 6
);
  logic              s_valid;
  logic              s_ready;
  logic [DW-1:0]     s_data;
  logic              s_last;
  logic              t_valid;
  logic              t_ready;
  logic [DW*TAP-1:0] t_data;
  logic              t_last;

  modport master (
    output s_valid, s_data, s_last, t_ready,
    input  s_ready, t_valid, t_data, t_last
  );

  modport slave (
    input  s_valid, s_data, s_last, t_ready,
    output s_ready, t_valid, t_data, t_last
  );
endinterface

// File: rtl/wc_tile_feeder.sv
// Builds overlapping TAP-sample tiles with stride STRIDE from a per-row sample stream,
// zero-padding the final tile of each row so every real sample lands in some tile.
module wc_tile_feeder #(
  parameter int unsigned DW     = 10,
  parameter int unsigned TAP    = 6,
  parameter int unsigned STRIDE = 2
) (
  input logic             clk,
  input logic             rst,
  wc_tile_feeder_if.slave bus
);

  localparam int unsigned FW = $clog2(TAP + 1);
  localparam logic [FW-1:0] FillFull = FW'(TAP);
  localparam logic [FW-1:0] FillKeep = FW'(TAP - STRIDE);

  if (STRIDE == 0 || STRIDE >= TAP) begin : g_param_check
    $error("wc_tile_feeder: TAP > STRIDE >= 1 is required");
  end

  typedef enum logic [1:0] {StFill, StPad, StDrain} state_e;

  state_e            state_q, state_d;
  logic [DW-1:0]     win_q [TAP];
  logic [DW-1:0]     win_d [TAP];
  logic [FW-1:0]     fill_q, fill_d;
  logic [DW*TAP-1:0] tile_q, tile_d;
  logic              t_valid_q, t_valid_d;
  logic              t_last_q, t_last_d;

  logic              full;
  logic              can_xfer;
  logic              accept;
  logic              xfer;
  logic              xfer_last;
  logic              shift;
  logic              wr_en;
  logic [FW-1:0]     wr_pos;
  logic [FW-1:0]     wr_next;
  logic [DW-1:0]     wr_data;
  logic [DW*TAP-1:0] win_flat;

  assign full          = (fill_q == FillFull);
  assign can_xfer      = !t_valid_q | bus.t_ready;
  assign bus.s_ready   = (state_q == StFill) & (!full | can_xfer);
  assign accept        = bus.s_valid & bus.s_ready;

  assign bus.t_valid   = t_valid_q;
  assign bus.t_data    = tile_q;
  assign bus.t_last    = t_last_q;

  always_comb begin
    win_flat = '0;
    for (int unsigned i = 0; i < TAP; i++) begin
      win_flat[DW*i +: DW] = win_q[i];
    end
  end

  // Next-state: FSM, window write position and stride shift.
  always_comb begin
    state_d   = state_q;
    fill_d    = fill_q;
    xfer      = 1'b0;
    xfer_last = 1'b0;
    shift     = 1'b0;
    wr_en     = 1'b0;
    wr_pos    = fill_q;
    wr_data   = '0;

    unique case (state_q)
      StFill: begin
        if (full && can_xfer) begin
          xfer   = 1'b1;
          shift  = 1'b1;
          fill_d = FillKeep;
          wr_pos = FillKeep;
        end
        if (accept) begin
          wr_en   = 1'b1;
          wr_data = bus.s_data;
          fill_d  = wr_next;
          if (bus.s_last) begin
            state_d = (wr_next == FillFull) ? StDrain : StPad;
          end
        end
      end
      StPad: begin
        wr_en  = 1'b1;
        fill_d = wr_next;
        if (wr_next == FillFull) begin
          state_d = StDrain;
        end
      end
      StDrain: begin
        if (can_xfer) begin
          xfer      = 1'b1;
          xfer_last = 1'b1;
          fill_d    = '0;
          state_d   = StFill;
        end
      end
      default: begin
        state_d = StFill;
      end
    endcase
  end

  assign wr_next = wr_pos + 1'b1;

  always_comb begin
    win_d = win_q;
    if (shift) begin
      for (int unsigned i = 0; i < TAP - STRIDE; i++) begin
        win_d[i] = win_q[i + STRIDE];
      end
    end
    // The write lands after the shift so a same-cycle accept goes to TAP-STRIDE.
    for (int unsigned i = 0; i < TAP; i++) begin
      if (wr_en && (wr_pos == FW'(i))) begin
        win_d[i] = wr_data;
      end
    end
  end

  always_comb begin
    tile_d    = tile_q;
    t_valid_d = t_valid_q;
    t_last_d  = t_last_q;
    if (xfer) begin
      tile_d    = win_flat;
      t_valid_d = 1'b1;
      t_last_d  = xfer_last;
    end else if (bus.t_ready) begin
      t_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StFill;
      fill_q    <= '0;
      tile_q    <= '0;
      t_valid_q <= 1'b0;
      t_last_q  <= 1'b0;
      for (int unsigned i = 0; i < TAP; i++) begin
        win_q[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      fill_q    <= fill_d;
      tile_q    <= tile_d;
      t_valid_q <= t_valid_d;
      t_last_q  <= t_last_d;
      win_q     <= win_d;
    end
  end

  tile_hold_a: assert property (@(posedge clk) disable iff (rst)
    (t_valid_q && !bus.t_ready) |=> (t_valid_q && $stable(tile_q) && $stable(t_last_q)));

  fill_range_a: assert property (@(posedge clk) disable iff (rst) fill_q <= FillFull);

endmodule

// File: tb/tb_wc_tile_feeder.sv
// Randomised and directed bench for wc_tile_feeder; expected tiles come from a
// row-level model that cuts each row into stride-2 windows with zero fill.
module tb_wc_tile_feeder;

  localparam int unsigned DW     = 10;
  localparam int unsigned TAP    = 6;
  localparam int unsigned STRIDE = 2;
  localparam int unsigned TW     = DW * TAP;

  typedef struct packed {
    logic [TW-1:0] data;
    logic          last;
  } tile_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  wc_tile_feeder_if #(.DW(DW), .TAP(TAP)) bus ();

  wc_tile_feeder #(.DW(DW), .TAP(TAP), .STRIDE(STRIDE)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic rdy_mode  = 1'b0;
  logic rdy_force = 1'b1;
  logic rdy_rand  = 1'b1;
  assign bus.t_ready = rdy_mode ? rdy_rand : rdy_force;
  always @(posedge clk) rdy_rand <= ($urandom_range(0, 2) != 0);

  tile_t got_q[$];
  tile_t exp_q[$];
  int    got_base = 0;
  int    low_cnt  = 0;
  int    checks   = 0;
  int    errors   = 0;

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.t_valid && bus.t_ready) got_q.push_back('{data: bus.t_data, last: bus.t_last});
      if (!bus.s_ready) low_cnt++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  // Row-level reference: windows start at 0, STRIDE, ...; the first window that
  // reaches the row end is the last one and is zero-filled past the row.
  task automatic model_row(input logic [DW-1:0] row[$]);
    int  n     = row.size();
    int  start = 0;
    bit  done  = 0;
    while (!done) begin
      tile_t t;
      t.data = '0;
      for (int i = 0; i < int'(TAP); i++) begin
        if (start + i < n) t.data[DW*i +: DW] = row[start + i];
      end
      done   = (start + int'(TAP) >= n);
      t.last = done;
      exp_q.push_back(t);
      start += STRIDE;
    end
  endtask

  function automatic int pad_cycles(input int n);
    int s = 0;
    while (s + int'(TAP) < n) s += STRIDE;
    return s + int'(TAP) - n;
  endfunction

  task automatic send_sample(input logic [DW-1:0] d, input bit last, input int gap);
    int t = 0;
    for (int g = 0; g < gap; g++) begin
      bus.s_valid = 1'b0;
      bus.s_last  = $urandom_range(0, 1);
      bus.s_data  = DW'($urandom);
      @(posedge clk); #1;
    end
    bus.s_valid = 1'b1;
    bus.s_data  = d;
    bus.s_last  = last;
    @(negedge clk);
    while (!bus.s_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (t >= 200) begin
      errors++;
      $display("FAIL send_timeout got s_ready=0 for %0d cycles want 1", t);
    end
    @(posedge clk); #1;
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
  endtask

  task automatic wait_tiles(input int want, input int bound, output bit ok);
    int t = 0;
    while (got_q.size() - got_base < want && t < bound) begin
      @(posedge clk); #1;
      t++;
    end
    repeat (4) begin
      @(posedge clk); #1;
    end
    ok = (got_q.size() - got_base == want);
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    checks += 4;
    if (bus.t_valid !== 1'b0) begin
      errors++; $display("FAIL reset_t_valid got %b want 0", bus.t_valid);
    end
    if (bus.t_last !== 1'b0) begin
      errors++; $display("FAIL reset_t_last got %b want 0", bus.t_last);
    end
    if (bus.t_data !== '0) begin
      errors++; $display("FAIL reset_t_data got %h want 0", bus.t_data);
    end
    if (bus.s_ready !== 1'b1) begin
      errors++; $display("FAIL reset_s_ready got %b want 1", bus.s_ready);
    end
  endtask

  task automatic test_row(input string nm, input logic [DW-1:0] row[$]);
    int n = row.size();
    int bub = 0;
    bit ok;
    exp_q.delete();
    model_row(row);
    got_base = got_q.size();
    for (int i = 0; i < n; i++) begin
      send_sample(row[i], (i == n - 1), 0);
      if (i == int'(TAP) - 1 && n > int'(TAP)) begin
        checks++;
        if (bus.t_valid !== 1'b0) begin
          errors++; $display("FAIL %s_latency_early got t_valid=%b want 0", nm, bus.t_valid);
        end
      end
      if (i == int'(TAP) && n > int'(TAP)) begin
        checks++;
        if (bus.t_valid !== 1'b1 || bus.t_data !== exp_q[0].data) begin
          errors++;
          $display("FAIL %s_latency got v=%b %h want v=1 %h", nm, bus.t_valid, bus.t_data,
                   exp_q[0].data);
        end
      end
    end
    while (!bus.s_ready && bub < 50) begin
      bub++;
      @(posedge clk); #1;
    end
    checks++;
    if (bub != pad_cycles(n) + 1) begin
      errors++; $display("FAIL %s_bubble got %0d want %0d", nm, bub, pad_cycles(n) + 1);
    end
    wait_tiles(exp_q.size(), 100, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s_count got %0d want %0d", nm, got_q.size() - got_base, exp_q.size());
    end
    foreach (exp_q[i]) begin
      tile_t g = (got_base + i < got_q.size()) ? got_q[got_base + i] : '0;
      checks++;
      if (g !== exp_q[i]) begin
        errors++;
        $display("FAIL %s_tile%0d got %h/%b want %h/%b", nm, i, g.data, g.last,
                 exp_q[i].data, exp_q[i].last);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] row[$];
    bit ok;
    for (int i = 1; i <= 8; i++) row.push_back(DW'(i));
    exp_q.delete();
    model_row(row);
    got_base = got_q.size();
    fork
      begin
        for (int i = 0; i < 8; i++) send_sample(row[i], (i == 7), 0);
      end
      begin
        int t = 0;
        while (!bus.t_valid && t < 100) begin
          @(posedge clk); #1;
          t++;
        end
        rdy_force = 1'b0;
        for (int k = 0; k < 5; k++) begin
          @(negedge clk);
          checks++;
          if (bus.t_valid !== 1'b1 || bus.t_data !== exp_q[0].data) begin
            errors++;
            $display("FAIL bp_hold%0d got v=%b %h want v=1 %h", k, bus.t_valid, bus.t_data,
                     exp_q[0].data);
          end
        end
        checks++;
        if (bus.s_ready !== 1'b0) begin
          errors++; $display("FAIL bp_s_ready got %b want 0", bus.s_ready);
        end
        @(posedge clk); #1;
        rdy_force = 1'b1;
      end
    join
    wait_tiles(exp_q.size(), 100, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL bp_count got %0d want %0d", got_q.size() - got_base, exp_q.size());
    end
    foreach (exp_q[i]) begin
      tile_t g = (got_base + i < got_q.size()) ? got_q[got_base + i] : '0;
      checks++;
      if (g !== exp_q[i]) begin
        errors++;
        $display("FAIL bp_tile%0d got %h/%b want %h/%b", i, g.data, g.last,
                 exp_q[i].data, exp_q[i].last);
      end
    end
  endtask

  task automatic test_mid_reset();
    logic [DW-1:0] row[$];
    bit ok;
    for (int i = 1; i <= 4; i++) send_sample(DW'(i), 1'b0, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks += 2;
    if (bus.t_valid !== 1'b0) begin
      errors++; $display("FAIL mrst_t_valid got %b want 0", bus.t_valid);
    end
    if (bus.s_ready !== 1'b1) begin
      errors++; $display("FAIL mrst_s_ready got %b want 1", bus.s_ready);
    end
    for (int i = 11; i <= 16; i++) row.push_back(DW'(i));
    exp_q.delete();
    model_row(row);
    got_base = got_q.size();
    for (int i = 0; i < 6; i++) send_sample(row[i], (i == 5), 0);
    wait_tiles(exp_q.size(), 100, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL mrst_count got %0d want %0d", got_q.size() - got_base, exp_q.size());
    end
    foreach (exp_q[i]) begin
      tile_t g = (got_base + i < got_q.size()) ? got_q[got_base + i] : '0;
      checks++;
      if (g !== exp_q[i]) begin
        errors++;
        $display("FAIL mrst_tile%0d got %h/%b want %h/%b", i, g.data, g.last,
                 exp_q[i].data, exp_q[i].last);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] r0[$];
    logic [DW-1:0] r1[$];
    int low0;
    bit ok;
    for (int i = 0; i < 8; i++) begin
      r0.push_back(DW'(21 + i));
      r1.push_back(DW'(31 + i));
    end
    exp_q.delete();
    model_row(r0);
    model_row(r1);
    got_base = got_q.size();
    low0 = low_cnt;
    for (int i = 0; i < 8; i++) send_sample(r0[i], (i == 7), 0);
    for (int i = 0; i < 8; i++) send_sample(r1[i], (i == 7), 0);
    wait_tiles(exp_q.size(), 100, ok);
    checks++;
    if (low_cnt - low0 != 2) begin
      errors++; $display("FAIL b2b_bubbles got %0d want 2", low_cnt - low0);
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL b2b_count got %0d want %0d", got_q.size() - got_base, exp_q.size());
    end
    foreach (exp_q[i]) begin
      tile_t g = (got_base + i < got_q.size()) ? got_q[got_base + i] : '0;
      checks++;
      if (g !== exp_q[i]) begin
        errors++;
        $display("FAIL b2b_tile%0d got %h/%b want %h/%b", i, g.data, g.last,
                 exp_q[i].data, exp_q[i].last);
      end
    end
  endtask

  task automatic test_random();
    bit ok;
    exp_q.delete();
    got_base = got_q.size();
    rdy_mode = 1'b1;
    for (int r = 0; r < 12; r++) begin
      logic [DW-1:0] row[$];
      int n = $urandom_range(1, 20);
      for (int i = 0; i < n; i++) row.push_back(DW'($urandom));
      model_row(row);
      for (int i = 0; i < n; i++) begin
        send_sample(row[i], (i == n - 1), ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0);
      end
    end
    wait_tiles(exp_q.size(), 2000, ok);
    rdy_mode = 1'b0;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL rand_count got %0d want %0d", got_q.size() - got_base, exp_q.size());
    end
    foreach (exp_q[i]) begin
      tile_t g = (got_base + i < got_q.size()) ? got_q[got_base + i] : '0;
      checks++;
      if (g !== exp_q[i]) begin
        errors++;
        $display("FAIL rand_tile%0d got %h/%b want %h/%b", i, g.data, g.last,
                 exp_q[i].data, exp_q[i].last);
      end
    end
  endtask

  initial begin
    logic [DW-1:0] row[$];
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
    bus.s_data  = '0;
    test_reset();

    row.delete();
    for (int i = 1; i <= 8; i++) row.push_back(DW'(i));
    test_row("row8", row);

    row.delete();
    for (int i = 1; i <= 9; i++) row.push_back(DW'(i));
    test_row("row9", row);

    row.delete();
    row.push_back(10'h3FF);
    test_row("single", row);

    test_backpressure();
    test_mid_reset();
    test_back_to_back();
    test_random();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
